// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD unit: FSM state encoding and default operand width.
package gcd_pkg;
  localparam int GCD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_B  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/gcd_if.sv
// Request/result bundle of the GCD unit: the operand bus and start request in, the result and done flag out.
interface gcd_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             done;
  logic [WIDTH-1:0] gcd_out;

  modport master (output start, output data_in, input done, input gcd_out);
  modport slave  (input start, input data_in, output done, output gcd_out);
endinterface

// File: rtl/gcd_datapath.sv
// Operand registers, larger-minus-smaller subtractors, input mux, comparison flags and result register.
module gcd_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             sel_sub,
  input  logic             ld_res,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             zero,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;

  assign gt   = (a > b);
  assign lt   = (a < b);
  assign eq   = (a == b);
  assign zero = (a == '0) || (b == '0);

  // Each difference is only selected when its minuend is the larger operand, so it never wraps.
  assign a_minus_b = a - b;
  assign b_minus_a = b - a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      result <= '0;
    end else begin
      if (ld_a)   a      <= sel_sub ? a_minus_b : data_in;
      if (ld_b)   b      <= sel_sub ? b_minus_a : data_in;
      if (ld_res) result <= zero ? (a | b) : a;
    end
  end
endmodule

// File: rtl/gcd_unit.sv
// Subtractive GCD engine: FSM sequencing operand capture, one subtraction per cycle, and result hold.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input logic   clk,
  input logic   rst_n,
  gcd_if.slave  bus
);
  state_t state, state_nxt;
  logic   ld_a, ld_b, sel_sub, ld_res;
  logic   gt, lt, eq, zero;
  logic [WIDTH-1:0] result;

  gcd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (bus.data_in),
    .ld_a    (ld_a),
    .ld_b    (ld_b),
    .sel_sub (sel_sub),
    .ld_res  (ld_res),
    .gt      (gt),
    .lt      (lt),
    .eq      (eq),
    .zero    (zero),
    .result  (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    sel_sub   = 1'b0;
    ld_res    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          ld_a      = 1'b1;
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        ld_b      = 1'b1;
        state_nxt = COMPARE;
      end
      COMPARE: begin
        if (zero || eq) begin
          ld_res    = 1'b1;
          state_nxt = DONE;
        end else if (gt) begin
          ld_a    = 1'b1;
          sel_sub = 1'b1;
        end else if (lt) begin
          ld_b    = 1'b1;
          sel_sub = 1'b1;
        end
      end
      DONE: begin
        // A held start keeps the result presented; the request must drop before a new run.
        if (!bus.start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // done decodes the state register directly, so it is as registered as the state itself.
  assign bus.done    = (state == DONE);
  assign bus.gcd_out = result;
endmodule

// File: tb/tb_gcd_unit.sv
// Directed bench for gcd_unit: operand table plus hand sequences for hold, reset and narrow width.
module tb_gcd_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gcd_if #(.WIDTH(8)) if8 ();
  gcd_if #(.WIDTH(4)) if4 ();

  gcd_unit #(.WIDTH(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  gcd_unit #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    int         edges;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one computation on the 8-bit unit; edges counts from the start-sampling edge.
  task automatic compute(input logic [7:0] a, input logic [7:0] b, input bit keep_start,
                         output int edges, output logic [7:0] res);
    @(negedge clk);
    if8.start   = 1'b1;
    if8.data_in = a;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    if8.data_in = b;
    if8.start   = keep_start;
    while (edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (if8.done === 1'b1) break;
    end
    res = if8.gcd_out;
  endtask

  initial begin
    int         e;
    logic [7:0] r;

    vecs[0] = '{a: 8'd48,  b: 8'd18,  exp: 8'd6,   edges: 7};
    vecs[1] = '{a: 8'd100, b: 8'd100, exp: 8'd100, edges: 3};
    vecs[2] = '{a: 8'd255, b: 8'd1,   exp: 8'd1,   edges: 257};
    vecs[3] = '{a: 8'd0,   b: 8'd37,  exp: 8'd37,  edges: 3};
    vecs[4] = '{a: 8'd0,   b: 8'd0,   exp: 8'd0,   edges: 3};
    vecs[5] = '{a: 8'd37,  b: 8'd0,   exp: 8'd37,  edges: 3};
    vecs[6] = '{a: 8'd12,  b: 8'd8,   exp: 8'd4,   edges: 5};
    vecs[7] = '{a: 8'd7,   b: 8'd13,  exp: 8'd1,   edges: 10};

    if8.start = 1'b0; if8.data_in = '0;
    if4.start = 1'b0; if4.data_in = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_done", {31'd0, if8.done}, 32'd0);
    chk("reset_gcd",  {24'd0, if8.gcd_out}, 32'd0);
    rst_n = 1'b1;

    // (91,234) with start held high: result stays presented, no restart.
    compute(8'd91, 8'd234, 1'b1, e, r);
    chk("g91_234", {24'd0, r}, 32'd13);
    chk("g91_234_edges", e, 32'd9);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_done", {31'd0, if8.done}, 32'd1);
      chk("hold_gcd",  {24'd0, if8.gcd_out}, 32'd13);
    end
    if8.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("release_done", {31'd0, if8.done}, 32'd0);
    chk("release_gcd",  {24'd0, if8.gcd_out}, 32'd13);

    for (int i = 0; i < 8; i++) begin
      compute(vecs[i].a, vecs[i].b, 1'b0, e, r);
      chk($sformatf("gcd_%0d_%0d", vecs[i].a, vecs[i].b), {24'd0, r}, {24'd0, vecs[i].exp});
      chk($sformatf("edges_%0d_%0d", vecs[i].a, vecs[i].b), e, vecs[i].edges);
      @(posedge clk);
      @(negedge clk);
      chk("idle_done", {31'd0, if8.done}, 32'd0);
      chk("idle_gcd_kept", {24'd0, if8.gcd_out}, {24'd0, vecs[i].exp});
    end

    // Reset during COMPARE of (255,1), with a nonzero result (1) still held from the table.
    @(negedge clk);
    if8.start   = 1'b1;
    if8.data_in = 8'd255;
    @(posedge clk);
    @(negedge clk);
    if8.data_in = 8'd1;
    if8.start   = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", {31'd0, if8.done}, 32'd0);
    chk("midrst_gcd",  {24'd0, if8.gcd_out}, 32'd0);
    #2;
    rst_n = 1'b1;
    compute(8'd12, 8'd8, 1'b0, e, r);
    chk("post_rst_gcd", {24'd0, r}, 32'd4);
    chk("post_rst_edges", e, 32'd5);

    // Narrow instance: (15,10) -> 5 after (15,10)->(5,10)->(5,5).
    @(negedge clk);
    if4.start   = 1'b1;
    if4.data_in = 4'd15;
    @(posedge clk);
    e = 1;
    @(negedge clk);
    if4.data_in = 4'd10;
    if4.start   = 1'b0;
    while (e < 50) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (if4.done === 1'b1) break;
    end
    chk("w4_gcd", {28'd0, if4.gcd_out}, 32'd5);
    chk("w4_edges", e, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
